sha256_msg_sched: RTL and testbench



---
 rtl/sha256_pkg.sv | 31 +++
 rtl/SIG0.sv | 13 +
 rtl/SIG1.sv | 13 +
 rtl/sha256_msg_sched.sv | 123 ++++++++++++
 tb/tb_sha256_msg_sched.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state type and rotate helper for the SHA-256 message-schedule slice.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package sha256_pkg;

   // Words per 512-bit block and schedule words emitted per block
   localparam int BLOCK_WORDS = 16;
   localparam int NUM_ROUNDS  = 64;

   // Small-sigma 0: ROTR7 ^ ROTR18 ^ SHR3
   localparam int S0_ROT_A = 7;
   localparam int S0_ROT_B = 18;
   localparam int S0_SHR   = 3;

   // Small-sigma 1: ROTR17 ^ ROTR19 ^ SHR10
   localparam int S1_ROT_A = 17;
   localparam int S1_ROT_B = 19;
   localparam int S1_SHR   = 10;

   // Scheduler phase: collecting the block, or streaming W0..W63
   typedef enum logic {
      LOAD = 1'b0,
      OUT  = 1'b1
   } sched_state_e;

   // 32-bit rotate right; amounts are elaboration-time constants in 1..31
   function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

endpackage

// File: rtl/SIG0.sv
// SHA-256 small sigma-0: ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
// Latency: purely combinational.
// Backpressure: none; output follows input.
module SIG0
   import sha256_pkg::*;
(
   input  logic [31:0] x_in,
   output logic [31:0] y_out
);

   assign y_out = rotr32(x_in, S0_ROT_A) ^ rotr32(x_in, S0_ROT_B) ^ (x_in >> S0_SHR);

endmodule

// File: rtl/SIG1.sv
// SHA-256 small sigma-1: ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
// Latency: purely combinational.
// Backpressure: none; output follows input.
module SIG1
   import sha256_pkg::*;
(
   input  logic [31:0] x_in,
   output logic [31:0] y_out
);

   assign y_out = rotr32(x_in, S1_ROT_A) ^ rotr32(x_in, S1_ROT_B) ^ (x_in >> S1_SHR);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads W0..W15 through a 16-word shift window, then streams W0..W63.
// Latency: first output word W0 is valid the cycle after the 16th input handshake; one word per beat.
// Backpressure: S_ready_out only in LOAD; D_ready_in low freezes window, t and D_W_out. Optional D_t_out under SHA256_SCHED_TIDX_EN.
module sha256_msg_sched
   import sha256_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] S_word_in,
   input  logic                  S_valid_in,
   output logic                  S_ready_out,
   output logic [DATA_WIDTH-1:0] D_W_out,
   output logic                  D_valid_out,
   input  logic                  D_ready_in,
   output logic                  D_last_out
`ifdef SHA256_SCHED_TIDX_EN
  ,output logic [5:0]            D_t_out
`endif
);

   sched_state_e          state_q, state_d;
   logic [3:0]            ld_cnt_q, ld_cnt_d;
   logic [5:0]            t_q, t_d;
   logic [DATA_WIDTH-1:0] w_q [BLOCK_WORDS];
   logic [DATA_WIDTH-1:0] w_d [BLOCK_WORDS];

   logic [DATA_WIDTH-1:0] sig0_w;
   logic [DATA_WIDTH-1:0] sig1_w;
   logic [DATA_WIDTH-1:0] w_new;
   logic                  s_hs;
   logic                  d_hs;
   logic                  ld_last;
   logic                  t_last;

   // Recurrence W_{t+16} = s1(W_{t+14}) + W_{t+9} + s0(W_{t+1}) + W_t, with w[0] holding W_t
   SIG0 u_sig0 (
      .x_in  (w_q[1]),
      .y_out (sig0_w)
   );

   SIG1 u_sig1 (
      .x_in  (w_q[14]),
      .y_out (sig1_w)
   );

   assign w_new = sig1_w + w_q[9] + sig0_w + w_q[0];

   // Ready is masked during reset so nothing is taken on the reset edge
   assign S_ready_out = (state_q == LOAD) && !rst;
   assign D_valid_out = (state_q == OUT);
   assign D_W_out     = w_q[0];

   assign ld_last    = (ld_cnt_q == 4'(BLOCK_WORDS - 1));
   assign t_last     = (t_q == 6'(NUM_ROUNDS - 1));
   assign D_last_out = D_valid_out && t_last;

   assign s_hs = S_valid_in && S_ready_out;
   assign d_hs = D_valid_out && D_ready_in;

`ifdef SHA256_SCHED_TIDX_EN
   assign D_t_out = t_q;
`endif

   // Phase and counter sequencing; both counters wrap to 0 on their final handshake
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      t_d      = t_q;
      case (state_q)
         LOAD: begin
            if (s_hs) begin
               ld_cnt_d = ld_cnt_q + 4'd1;
               if (ld_last) begin
                  state_d  = OUT;
                  ld_cnt_d = 4'd0;
                  t_d      = 6'd0;
               end
            end
         end
         OUT: begin
            if (d_hs) begin
               t_d = t_q + 6'd1;
               if (t_last) begin
                  state_d = LOAD;
                  t_d     = 6'd0;
               end
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Window shifts toward w[0] on either handshake; the new tail is the input word or the recurrence
   always_comb begin
      w_d = w_q;
      if (s_hs || d_hs) begin
         for (int i = 0; i < BLOCK_WORDS - 1; i++) begin
            w_d[i] = w_q[i+1];
         end
         w_d[BLOCK_WORDS-1] = s_hs ? S_word_in : w_new;
      end
   end

   // State registers with synchronous reset; an abort drops any partial block
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LOAD;
         ld_cnt_q <= 4'd0;
         t_q      <= 6'd0;
         w_q      <= '{default: '0};
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
         t_q      <= t_d;
         w_q      <= w_d;
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: known-answer spot vectors plus a reference schedule model.
// Latency: checks W0 on the cycle after the 16th load handshake.
// Backpressure: exercises output stalls, input gaps, inputs during OUT and mid-stream reset.
`timescale 1ns/1ps
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] S_word_in = '0;
   logic        S_valid_in = 1'b0;
   logic        S_ready_out;
   logic [31:0] D_W_out;
   logic        D_valid_out;
   logic        D_ready_in = 1'b1;
   logic        D_last_out;
`ifdef SHA256_SCHED_TIDX_EN
   logic [5:0]  D_t_out;
`endif

   always #5 clk = ~clk;

   sha256_msg_sched #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .S_word_in   (S_word_in),
      .S_valid_in  (S_valid_in),
      .S_ready_out (S_ready_out),
      .D_W_out     (D_W_out),
      .D_valid_out (D_valid_out),
      .D_ready_in  (D_ready_in),
      .D_last_out  (D_last_out)
`ifdef SHA256_SCHED_TIDX_EN
     ,.D_t_out     (D_t_out)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] blk   [16];
   logic [31:0] exp_w [64];
   logic [31:0] cap_w [64];
   logic        cap_last [64];

   typedef struct {
      string       name;
      int          idx;
      logic [31:0] exp_v;
   } vec_t;

   vec_t abc_vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
   endtask

   function automatic logic [31:0] m_sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] m_sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   task automatic build_model();
      for (int t = 0; t < 16; t++) exp_w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         exp_w[t] = m_sig1(exp_w[t-2]) + exp_w[t-7] + m_sig0(exp_w[t-15]) + exp_w[t-16];
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      build_model();
   endtask

   // Presents blk[start..15]; returns with the last handshake pending on the next rising edge
   task automatic load_block(input bit gaps, input int start);
      int i   = start;
      int cyc = 0;
      while (i < 16 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (gaps && $urandom_range(0, 1) == 1) begin
            S_valid_in = 1'b0;
         end else begin
            S_valid_in = 1'b1;
            S_word_in  = blk[i];
         end
         #1;
         if (S_valid_in && S_ready_out) i++;
      end
      chk("load_accepted", 32'(i), 32'd16);
   endtask

   // Collects n beats; optional stall of stall_len cycles once stall_at beats have been taken
   task automatic collect(input int n, input int stall_at, input int stall_len,
                          input bit hold_valid, input logic [31:0] hold_word);
      int beats      = 0;
      int cyc        = 0;
      int stall_left = stall_len;
      bit first      = 1'b1;
      while (beats < n && cyc < 300) begin
         @(negedge clk);
         cyc++;
         S_valid_in = hold_valid;
         S_word_in  = hold_valid ? hold_word : 32'h0;
         if (beats == stall_at && stall_left > 0) begin
            D_ready_in = 1'b0;
            stall_left--;
         end else begin
            D_ready_in = 1'b1;
         end
         #1;
         if (first) begin
            chk("first_beat_valid", 32'(D_valid_out), 32'd1);
            chk("first_beat_w0", D_W_out, exp_w[0]);
            first = 1'b0;
         end
         if (hold_valid) chk("s_ready_low_in_out", 32'(S_ready_out), 32'd0);
         if (!D_ready_in) begin
            chk("stall_word_hold", D_W_out, exp_w[stall_at]);
            chk("stall_valid_hold", 32'(D_valid_out), 32'd1);
`ifdef SHA256_SCHED_TIDX_EN
            chk("stall_t_hold", 32'(D_t_out), 32'(stall_at));
`endif
         end else if (D_valid_out) begin
`ifdef SHA256_SCHED_TIDX_EN
            chk("t_index", 32'(D_t_out), 32'(beats));
`endif
            cap_w[beats]    = D_W_out;
            cap_last[beats] = D_last_out;
            beats++;
         end
      end
      chk("beat_count", 32'(beats), 32'(n));
   endtask

   task automatic check_stream(input string tag);
      for (int b = 0; b < 64; b++) begin
         chk($sformatf("%s_w%0d", tag, b), cap_w[b], exp_w[b]);
         chk($sformatf("%s_last%0d", tag, b), 32'(cap_last[b]), (b == 63) ? 32'd1 : 32'd0);
      end
   endtask

   // Cycle after beat 63: back in LOAD, no further output
   task automatic check_after_block(input string tag);
      @(negedge clk);
      #1;
      chk($sformatf("%s_valid_drop", tag), 32'(D_valid_out), 32'd0);
      chk($sformatf("%s_ready_back", tag), 32'(S_ready_out), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] blk2 [16];

      abc_vecs[0] = '{"abc_W0",  0,  32'h61626380};
      abc_vecs[1] = '{"abc_W1",  1,  32'h00000000};
      abc_vecs[2] = '{"abc_W15", 15, 32'h00000018};
      abc_vecs[3] = '{"abc_W16", 16, 32'h61626380};
      abc_vecs[4] = '{"abc_W17", 17, 32'h000F0000};
      abc_vecs[5] = '{"abc_W63", 63, 32'h12B1EDEB};

      // Reset behaviour
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_ready_forced_low", 32'(S_ready_out), 32'd0);
      @(negedge clk);
      #1;
      chk("rst_valid", 32'(D_valid_out), 32'd0);
      chk("rst_last", 32'(D_last_out), 32'd0);
      chk("rst_window_w0", D_W_out, 32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(S_ready_out), 32'd1);

      // "abc" block, no stalls
      set_abc();
      load_block(1'b0, 0);
      collect(64, -1, 0, 1'b0, 32'h0);
      for (int v = 0; v < 6; v++) chk(abc_vecs[v].name, cap_w[abc_vecs[v].idx], abc_vecs[v].exp_v);
      check_stream("abc");
      check_after_block("abc");

      // All-zero block
      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      build_model();
      load_block(1'b0, 0);
      collect(64, -1, 0, 1'b0, 32'h0);
      check_stream("zero");
      check_after_block("zero");

      // Output stall of 3 cycles at t = 20
      set_abc();
      load_block(1'b0, 0);
      collect(64, 20, 3, 1'b0, 32'h0);
      check_stream("stall");
      check_after_block("stall");

      // Input held valid through OUT; next block's first word offered early
      for (int i = 0; i < 16; i++) blk2[i] = (32'(i) * 32'h01234567) ^ 32'hDEADBEEF;
      set_abc();
      load_block(1'b0, 0);
      collect(64, -1, 0, 1'b1, blk2[0]);
      check_stream("held_a");
      check_after_block("held_a");
      for (int i = 0; i < 16; i++) blk[i] = blk2[i];
      build_model();
      load_block(1'b0, 1);
      collect(64, -1, 0, 1'b0, 32'h0);
      check_stream("held_b");
      check_after_block("held_b");

      // Reset pulse at t = 30, then a fresh "abc" run
      set_abc();
      load_block(1'b0, 0);
      collect(30, -1, 0, 1'b0, 32'h0);
      @(negedge clk);
      #1;
      chk("pre_rst_w30", D_W_out, exp_w[30]);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_valid", 32'(D_valid_out), 32'd0);
      chk("midrst_last", 32'(D_last_out), 32'd0);
      chk("midrst_ready_low", 32'(S_ready_out), 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst_ready_release", 32'(S_ready_out), 32'd1);
      load_block(1'b0, 0);
      collect(64, -1, 0, 1'b0, 32'h0);
      for (int v = 0; v < 6; v++) chk({"rst_", abc_vecs[v].name}, cap_w[abc_vecs[v].idx], abc_vecs[v].exp_v);
      check_stream("post_rst");
      check_after_block("post_rst");

      // Random input gaps during load
      load_block(1'b1, 0);
      collect(64, -1, 0, 1'b0, 32'h0);
      check_stream("gaps");
      check_after_block("gaps");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
